// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: digit word capture inputs and
// the multiplexed common-anode drive outputs.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_done;

    modport master (
        output data_in, dp_in, blank_in, load,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  data_in, dp_in, blank_in, load,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// buffer promotion and blanking dead-time before every digit slot.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int DEAD_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_scan_driver_if.slave     bus
);
    localparam int CNT_MAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_CYC - 1);
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {BLANK, DRIVE} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        an_d         = an_q;
        seg_d        = seg_q;
        dp_d         = dp_q;
        frame_done_d = 1'b0;

        if (bus.load) begin
            pend_data_d  = bus.data_in;
            pend_dp_d    = bus.dp_in;
            pend_blank_d = bus.blank_in;
        end

        case (state_q)
            BLANK: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    if (!act_blank_q[idx_q]) begin
                        an_d        = '1;
                        an_d[idx_q] = 1'b0;
                        seg_d       = hex_decode(act_data_q[{idx_q, 2'b00} +: 4]);
                        dp_d        = ~act_dp_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRIVE: begin
                if (cnt_q == SCAN_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    an_d    = '1;
                    seg_d   = 7'h7F;
                    dp_d    = 1'b1;
                    if (idx_q == DIGIT_LAST) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        // A load on the frame-end edge bypasses pending straight into active.
                        act_data_d   = pend_data_d;
                        act_dp_d     = pend_dp_d;
                        act_blank_d  = pend_blank_d;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed seven-segment display driver placed directly downstream of system_top. It consumes the hex values system_top produces and drives the board's common-anode digit enables and segment lines.
- Captures a digit word into a pending buffer and promotes it to the displayed buffer only at frame boundaries, so a frame never mixes old and new digits.
- Scans one digit at a time and inserts blanking dead-time between digits to suppress ghosting.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..8).
- SCAN_DIV, 100000, clk cycles each digit is driven (1 ms at Tclk = 10 ns); minimum 1.
- DEAD_CYC, 2, clk cycles all digits are blanked before each digit is driven; minimum 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  4*NUM_DIGITS  hex nibbles; nibble i = data_in[4i+3:4i] is shown on digit i.
- dp_in  input  NUM_DIGITS  decimal point per digit; 1 = lit.
- blank_in  input  NUM_DIGITS  per-digit blank; 1 = digit dark.
- load  input  1  capture strobe for data_in, dp_in and blank_in.
- an  output  NUM_DIGITS  digit enables, active-low.
- seg  output  7  segments, active-low; seg[0] = a through seg[6] = g.
- dp  output  1  decimal point, active-low.
- frame_done  output  1  one-cycle pulse at the end of each full frame.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: an = all 1s, seg = 7'h7F, dp = 1, frame_done = 0. Internally: state = BLANK, idx = 0, prescaler = 0, pending and active buffers = 0 (data, dp and blank all 0).
- After reset release with no load, every digit displays "0".
- All outputs are registered and take their new values in the first cycle of the new state.
- BLANK state:
  - Lasts exactly DEAD_CYC cycles.
  - Outputs: an = all 1s, seg = 7'h7F, dp = 1.
  - Then transitions to DRIVE.
- DRIVE state:
  - Lasts exactly SCAN_DIV cycles.
  - Outputs: an[idx] = 0 and all other an bits = 1; seg = decode(active nibble idx); dp = ~active_dp[idx].
  - If active_blank[idx] = 1: an = all 1s, seg = 7'h7F, dp = 1. The slot time is still consumed.
  - Outputs are frozen for the whole slot.
  - On the last cycle of DRIVE:
    - idx increments; it wraps from NUM_DIGITS-1 to 0.
    - State returns to BLANK.
- Frame end:
  - Occurs on the last DRIVE cycle of idx = NUM_DIGITS-1.
  - frame_done = 1 for exactly the first BLANK cycle that follows.
  - In the same edge, active <= pending.
- Digit period is DEAD_CYC + SCAN_DIV cycles; frame period is NUM_DIGITS * (DEAD_CYC + SCAN_DIV) cycles.
- Load handling:
  - load = 1 writes data_in, dp_in and blank_in into pending on that edge.
  - Multiple loads within one frame: only the last load is kept.
  - load in the same cycle as a frame end: the loaded values go directly into active as well as pending, so they are displayed in the next frame.
- Hex decode, active-low g..a: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Reset asserted mid-scan: all outputs return to their reset values immediately, without waiting for clk. The scan restarts from BLANK with idx = 0 after release; pending and active are cleared.
- The prescaler and dead-time counters are sized by $clog2 of their max value. No other wrap-around exists besides idx.

Test Plan:
- Bench parameters for all cases: NUM_DIGITS = 4, SCAN_DIV = 4, DEAD_CYC = 2.
- Reset then release, no load -> an = 1111 for 2 cycles, then 1110 for 4 cycles with seg = 7'h40. Pattern then steps 1101, 1011, 0111. frame_done pulses once every 24 cycles.
- Load data_in = 16'hA5F0, dp_in = 4'b0100 mid-frame -> current frame is unchanged. Next frame shows digit0 seg = 40, digit1 seg = 0E, digit2 seg = 12 with dp = 0, digit3 seg = 08.
- Load asserted on the same cycle as a frame end with data_in = 16'h1111 -> the very next frame shows seg = 79 on all digits.
- blank_in = 4'b0010 -> during digit1's 4-cycle slot an = 1111, seg = 7F, dp = 1. The slot timing is unchanged and digit2 starts on schedule.
- rst_n pulsed low during digit2 drive -> an = 1111, seg = 7F and frame_done = 0 without a clk edge. After release the scan restarts at BLANK then digit0 showing "0".
- Two loads in one frame (16'h1234, then 16'h5678) -> next frame displays 8, 7, 6, 5 on digits 0..3; 1234 is never displayed.
